sram_1p_access_ctrl: RTL and testbench

Request-side controller placed directly upstream of a single-port, set-indexed, way-masked SRAM macro (256 sets x 10 ways x 34 b, 1-cycle read latency, unregistered macro output). It does the following:
- arbitrates independent read and write request channels onto the macro's single RW port;
- runs a post-reset zeroing sweep;
- holds the last read data stable, because the raw macro output is only valid for the cycle after a read.

---
 rtl/sram_1p_access_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sram_1p_access_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1p_access_ctrl.sv
// sram_1p_access_ctrl
// Request-side controller for a single-port, set-indexed, way-masked SRAM
// macro (1-cycle read latency, unregistered macro output). It arbitrates a
// read and a write request channel onto the macro's single RW port, runs an
// optional post-reset zeroing sweep, and holds the last read response stable.
//
// Build option: define SRAM_INIT_SWEEP_EN to include the zeroing sweep (INIT
// state). Without it the array is usable on the first clock after reset.
//
// Ports:
//   clock, reset         clock and asynchronous active-low reset
//   r_req_*              read request channel (valid/ready, set index)
//   r_resp_valid/_data   read response pulse one cycle after accept; data held
//   w_req_*              write request channel (valid/ready, set, data, waymask)
//   sram_*               macro drive (addr, en, wmode, wmask, wdata) and rdata
//   init_done            high once the array is usable
module sram_1p_access_ctrl #(
   parameter int unsigned SETS    = 256,
   parameter int unsigned WAYS    = 10,
   parameter int unsigned WAY_W   = 34,
   parameter int unsigned WSTARVE = 4,
   localparam int unsigned ADDR_W = $clog2(SETS),
   localparam int unsigned DATA_W = WAYS * WAY_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              r_req_valid,
   output logic              r_req_ready,
   input  logic [ADDR_W-1:0] r_req_set,
   output logic              r_resp_valid,
   output logic [DATA_W-1:0] r_resp_data,
   input  logic              w_req_valid,
   output logic              w_req_ready,
   input  logic [ADDR_W-1:0] w_req_set,
   input  logic [DATA_W-1:0] w_req_data,
   input  logic [WAYS-1:0]   w_req_waymask,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_en,
   output logic              sram_wmode,
   output logic [WAYS-1:0]   sram_wmask,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              init_done
);

   localparam int unsigned CNT_W = 4;

   localparam logic [1:0] ST_BOOT = 2'd0;
`ifdef SRAM_INIT_SWEEP_EN
   localparam logic [1:0] ST_INIT = 2'd1;
`endif
   localparam logic [1:0] ST_RUN  = 2'd2;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [CNT_W-1:0]  wblk_cnt;
   logic              resp_pend;
   logic [DATA_W-1:0] hold_q;
   logic              starve;
   logic              r_acc;
   logic              w_acc;
`ifdef SRAM_INIT_SWEEP_EN
   logic [ADDR_W-1:0] init_cnt;
`endif

   assign starve = (wblk_cnt == CNT_W'(WSTARVE));

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
`ifdef SRAM_INIT_SWEEP_EN
         ST_BOOT: state_nxt = ST_INIT;
         ST_INIT: if (init_cnt == ADDR_W'(SETS - 1)) state_nxt = ST_RUN;
`else
         ST_BOOT: state_nxt = ST_RUN;
`endif
         ST_RUN:  state_nxt = ST_RUN;
         default: state_nxt = ST_BOOT;
      endcase
   end

   // Arbitration and macro drive; read wins unless the write has starved
   always_comb begin
      r_req_ready = 1'b0;
      w_req_ready = 1'b0;
      init_done   = 1'b0;
      r_acc       = 1'b0;
      w_acc       = 1'b0;
      sram_en     = 1'b0;
      sram_wmode  = 1'b0;
      sram_addr   = '0;
      sram_wmask  = '0;
      sram_wdata  = '0;
      if (state == ST_RUN) begin
         init_done = 1'b1;
         if (starve) begin
            w_req_ready = 1'b1;
            r_req_ready = !w_req_valid;
         end else begin
            r_req_ready = 1'b1;
            w_req_ready = !r_req_valid;
         end
         // the two accepts are mutually exclusive by construction
         r_acc = r_req_valid && r_req_ready;
         w_acc = w_req_valid && w_req_ready;
         if (r_acc) begin
            sram_en   = 1'b1;
            sram_addr = r_req_set;
         end else if (w_acc) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = w_req_set;
            sram_wmask = w_req_waymask;
            sram_wdata = w_req_data;
         end
      end
`ifdef SRAM_INIT_SWEEP_EN
      else if (state == ST_INIT) begin
         sram_en    = 1'b1;
         sram_wmode = 1'b1;
         sram_addr  = init_cnt;
         sram_wmask = '1;
      end
`endif
   end

   // State register and sweep counter
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_BOOT;
      end else begin
         state <= state_nxt;
      end
   end

`ifdef SRAM_INIT_SWEEP_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         init_cnt <= '0;
      end else if (state == ST_INIT) begin
         init_cnt <= init_cnt + ADDR_W'(1);
      end
   end
`endif

   // Write starvation counter: saturates while blocked, clears on accept
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wblk_cnt <= '0;
      end else if (w_acc) begin
         wblk_cnt <= '0;
      end else if (w_req_valid && !w_req_ready && !starve) begin
         wblk_cnt <= wblk_cnt + CNT_W'(1);
      end
   end

   // Response tracking: macro output is only valid the cycle after a read
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         resp_pend <= 1'b0;
         hold_q    <= '0;
      end else begin
         resp_pend <= r_acc;
         if (resp_pend) begin
            hold_q <= sram_rdata;
         end
      end
   end

   assign r_resp_valid = resp_pend;
   assign r_resp_data  = resp_pend ? sram_rdata : hold_q;

endmodule

// File: tb/tb_sram_1p_access_ctrl.sv
// tb_sram_1p_access_ctrl
// Self-checking bench: behavioural SRAM macro, a set-array reference model of
// the stored contents and the arbitration rules, a vector table for the
// starvation/priority sequence, hand-written corner sequences and random traffic.
module tb_sram_1p_access_ctrl;

   localparam int unsigned SETS    = 256;
   localparam int unsigned WAYS    = 10;
   localparam int unsigned WAY_W   = 34;
   localparam int unsigned WSTARVE = 4;
   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned DATA_W  = WAYS * WAY_W;
`ifdef SRAM_INIT_SWEEP_EN
   localparam bit SWEEP = 1'b1;
`else
   localparam bit SWEEP = 1'b0;
`endif
   localparam int RUN_AT = SWEEP ? int'(SETS) + 1 : 1;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              r_req_valid = 1'b0;
   logic              r_req_ready;
   logic [ADDR_W-1:0] r_req_set = '0;
   logic              r_resp_valid;
   logic [DATA_W-1:0] r_resp_data;
   logic              w_req_valid = 1'b0;
   logic              w_req_ready;
   logic [ADDR_W-1:0] w_req_set = '0;
   logic [DATA_W-1:0] w_req_data = '0;
   logic [WAYS-1:0]   w_req_waymask = '0;
   logic [ADDR_W-1:0] sram_addr;
   logic              sram_en;
   logic              sram_wmode;
   logic [WAYS-1:0]   sram_wmask;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata = '0;
   logic              init_done;

   sram_1p_access_ctrl dut (
      .clock(clock), .reset(reset),
      .r_req_valid(r_req_valid), .r_req_ready(r_req_ready), .r_req_set(r_req_set),
      .r_resp_valid(r_resp_valid), .r_resp_data(r_resp_data),
      .w_req_valid(w_req_valid), .w_req_ready(w_req_ready), .w_req_set(w_req_set),
      .w_req_data(w_req_data), .w_req_waymask(w_req_waymask),
      .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
      .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .init_done(init_done)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   function automatic logic [DATA_W-1:0] rand_data();
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < 11; i++) r = {r[DATA_W-33:0], 32'($urandom)};
      return r;
   endfunction

   function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                               input logic [DATA_W-1:0] data,
                                               input logic [WAYS-1:0] mask);
      logic [DATA_W-1:0] r;
      r = old;
      for (int w = 0; w < int'(WAYS); w++)
         if (mask[w]) r[w*WAY_W +: WAY_W] = data[w*WAY_W +: WAY_W];
      return r;
   endfunction

   // Behavioural macro: read data valid only the cycle after a read, garbage otherwise
   logic [DATA_W-1:0] mem [SETS];
   always @(posedge clock) begin
      if (sram_en && sram_wmode) mem[sram_addr] <= merge(mem[sram_addr], sram_wdata, sram_wmask);
      if (sram_en && !sram_wmode) sram_rdata <= mem[sram_addr];
      else                        sram_rdata <= rand_data();
   end

   // Reference model state
   logic [DATA_W-1:0] ref_mem [SETS];
   int                phase;
   int                blocked;
   bit                pend;
   logic [DATA_W-1:0] exp_data;

   task automatic model_reset();
      phase = 0; blocked = 0; pend = 1'b0; exp_data = '0;
   endtask

   task automatic chkw(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      chkw(name, DATA_W'(act), DATA_W'(exp));
   endtask

   task automatic reset_check(input string tag);
      chkb({tag, " r_req_ready"}, r_req_ready, 1'b0);
      chkb({tag, " w_req_ready"}, w_req_ready, 1'b0);
      chkb({tag, " init_done"}, init_done, 1'b0);
      chkb({tag, " sram_en"}, sram_en, 1'b0);
      chkb({tag, " sram_wmode"}, sram_wmode, 1'b0);
      chkw({tag, " sram_addr"}, DATA_W'(sram_addr), '0);
      chkw({tag, " sram_wmask"}, DATA_W'(sram_wmask), '0);
      chkw({tag, " sram_wdata"}, sram_wdata, '0);
      chkb({tag, " r_resp_valid"}, r_resp_valid, 1'b0);
      chkw({tag, " r_resp_data"}, r_resp_data, '0);
   endtask

   // One clock cycle: drive, predict, compare at negedge, advance model at posedge
   task automatic step(input bit rv, input logic [ADDR_W-1:0] rs,
                       input bit wv, input logic [ADDR_W-1:0] ws,
                       input logic [DATA_W-1:0] wd, input logic [WAYS-1:0] wm,
                       output bit o_rr, output bit o_wr, output bit o_en, output bit o_wmode,
                       output bit o_rv, output logic [DATA_W-1:0] o_rd);
      bit run, init, e_rr, e_wr, racc, wacc, e_en, e_wmode;
      int cnt;
      logic [ADDR_W-1:0] e_addr;
      logic [WAYS-1:0]   e_mask;
      logic [DATA_W-1:0] e_wdata;
      r_req_valid = rv; r_req_set = rs;
      w_req_valid = wv; w_req_set = ws; w_req_data = wd; w_req_waymask = wm;
      run  = (phase >= RUN_AT);
      init = SWEEP && phase >= 1 && !run;
      cnt  = phase - 1;
      e_rr = 1'b0; e_wr = 1'b0;
      if (run) begin
         if (blocked >= int'(WSTARVE)) begin e_wr = 1'b1; e_rr = !wv; end
         else begin e_rr = 1'b1; e_wr = !rv; end
      end
      racc = rv && e_rr;
      wacc = wv && e_wr;
      e_en = 1'b0; e_wmode = 1'b0; e_addr = '0; e_mask = '0; e_wdata = '0;
      if (init) begin e_en = 1'b1; e_wmode = 1'b1; e_addr = ADDR_W'(cnt); e_mask = '1; end
      else if (racc) begin e_en = 1'b1; e_addr = rs; end
      else if (wacc) begin e_en = 1'b1; e_wmode = 1'b1; e_addr = ws; e_mask = wm; e_wdata = wd; end
      @(negedge clock);
      chkb("r_req_ready", r_req_ready, e_rr);
      chkb("w_req_ready", w_req_ready, e_wr);
      chkb("init_done", init_done, run);
      chkb("sram_en", sram_en, e_en);
      chkb("sram_wmode", sram_wmode, e_wmode);
      chkw("sram_addr", DATA_W'(sram_addr), DATA_W'(e_addr));
      chkw("sram_wmask", DATA_W'(sram_wmask), DATA_W'(e_mask));
      chkw("sram_wdata", sram_wdata, e_wdata);
      chkb("r_resp_valid", r_resp_valid, pend);
      chkw("r_resp_data", r_resp_data, exp_data);
      o_rr = r_req_ready; o_wr = w_req_ready; o_en = sram_en; o_wmode = sram_wmode;
      o_rv = r_resp_valid; o_rd = r_resp_data;
      @(posedge clock);
      if (init) ref_mem[cnt] = '0;
      pend = racc;
      if (racc) exp_data = ref_mem[rs];
      if (wacc) ref_mem[ws] = merge(ref_mem[ws], wd, wm);
      if (wacc) blocked = 0;
      else if (wv && !e_wr && blocked < int'(WSTARVE)) blocked++;
      if (phase < RUN_AT) phase++;
      #1;
   endtask

   bit d_rr, d_wr, d_en, d_wm, d_rv;
   logic [DATA_W-1:0] d_rd;

   task automatic idle();
      step(1'b0, '0, 1'b0, '0, '0, '0, d_rr, d_wr, d_en, d_wm, d_rv, d_rd);
   endtask

   typedef struct {
      bit               rv;
      bit               wv;
      logic [ADDR_W-1:0] rs;
      logic [ADDR_W-1:0] ws;
      logic [WAYS-1:0]  wm;
      bit               e_rr;
      bit               e_wr;
      bit               e_en;
      bit               e_wmode;
   } vec_t;

   vec_t tbl [10];

   initial begin
      logic [DATA_W-1:0] dval;
      logic [DATA_W-1:0] v;
      logic [DATA_W-1:0] ones_way0;

      //          rv  wv  rs      ws      wm       rr  wr  en  wmode
      tbl[0] = '{1'b1, 1'b1, 8'h20, 8'h40, 10'h3FF, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 8'h21, 8'h40, 10'h3FF, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 1'b1, 8'h22, 8'h40, 10'h3FF, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 8'h23, 8'h40, 10'h3FF, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 1'b1, 8'h24, 8'h40, 10'h3FF, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[5] = '{1'b1, 1'b1, 8'h25, 8'h41, 10'h0F0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 8'h26, 8'h42, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 1'b1, 8'h27, 8'h43, 10'h155, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[8] = '{1'b1, 1'b0, 8'h43, 8'h44, 10'h000, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[9] = '{1'b0, 1'b1, 8'h28, 8'h45, 10'h000, 1'b1, 1'b1, 1'b1, 1'b1};

      for (int i = 0; i < int'(SETS); i++) begin
         v = rand_data();
         mem[i] <= v;
         ref_mem[i] = SWEEP ? '0 : v;
      end

      model_reset();
      repeat (2) @(posedge clock);
      #1 reset_check("por");
      #2 reset = 1'b1;

`ifdef SRAM_INIT_SWEEP_EN
      // abort the sweep while set 100 is being written, then restart from set 0
      repeat (101) idle();
      chkw("sweep_addr_before_abort", DATA_W'(sram_addr), DATA_W'(8'd100));
      reset = 1'b0;
      #1 reset_check("midsweep");
      repeat (2) @(posedge clock);
      #2 reset = 1'b1;
      model_reset();
`endif

      // boot (and sweep): no ready, init_done low until RUN
      for (int i = 0; i < RUN_AT; i++) idle();

      // starvation and priority vectors
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].rv, tbl[i].rs, tbl[i].wv, tbl[i].ws, {WAYS{WAY_W'(i + 1)}}, tbl[i].wm,
              d_rr, d_wr, d_en, d_wm, d_rv, d_rd);
         chkb($sformatf("vec%0d r_req_ready", i), d_rr, tbl[i].e_rr);
         chkb($sformatf("vec%0d w_req_ready", i), d_wr, tbl[i].e_wr);
         chkb($sformatf("vec%0d sram_en", i), d_en, tbl[i].e_en);
         chkb($sformatf("vec%0d sram_wmode", i), d_wm, tbl[i].e_wmode);
      end

      // write then read back, response held through idle cycles
      dval = {WAYS{34'h2DEADBEEF}};
      step(1'b0, '0, 1'b1, 8'h12, dval, 10'h3FF, d_rr, d_wr, d_en, d_wm, d_rv, d_rd);
      step(1'b1, 8'h12, 1'b0, '0, '0, '0, d_rr, d_wr, d_en, d_wm, d_rv, d_rd);
      idle();
      chkb("rd_resp_valid", d_rv, 1'b1);
      chkw("rd_resp_data", d_rd, dval);
      for (int i = 0; i < 10; i++) idle();
      chkb("hold_resp_valid", d_rv, 1'b0);
      chkw("hold_resp_data", d_rd, dval);

      // single-way write onto a zeroed set
      ones_way0 = '0;
      ones_way0[WAY_W-1:0] = '1;
      step(1'b0, '0, 1'b1, 8'h34, '0, 10'h3FF, d_rr, d_wr, d_en, d_wm, d_rv, d_rd);
      step(1'b0, '0, 1'b1, 8'h34, '1, 10'h001, d_rr, d_wr, d_en, d_wm, d_rv, d_rd);
      step(1'b1, 8'h34, 1'b0, '0, '0, '0, d_rr, d_wr, d_en, d_wm, d_rv, d_rd);
      idle();
      chkw("way0_write_data", d_rd, ones_way0);

      // write in the response cycle must not disturb the response
      step(1'b1, 8'h12, 1'b0, '0, '0, '0, d_rr, d_wr, d_en, d_wm, d_rv, d_rd);
      step(1'b0, '0, 1'b1, 8'h12, ~dval, 10'h3FF, d_rr, d_wr, d_en, d_wm, d_rv, d_rd);
      chkb("rw_resp_valid", d_rv, 1'b1);
      chkw("rw_resp_data", d_rd, dval);
      step(1'b1, 8'h12, 1'b0, '0, '0, '0, d_rr, d_wr, d_en, d_wm, d_rv, d_rd);
      idle();
      chkw("rw_new_data", d_rd, ~dval);

      // random traffic against the reference model
      for (int i = 0; i < 500; i++) begin
         step($urandom_range(0, 99) < 55, ADDR_W'($urandom_range(0, 7)),
              $urandom_range(0, 99) < 60, ADDR_W'($urandom_range(0, 7)),
              rand_data(), ($urandom_range(0, 9) == 0) ? '0 : WAYS'($urandom),
              d_rr, d_wr, d_en, d_wm, d_rv, d_rd);
      end

      // reset while a response is pending
      step(1'b1, 8'h12, 1'b0, '0, '0, '0, d_rr, d_wr, d_en, d_wm, d_rv, d_rd);
      r_req_valid = 1'b0;
      reset = 1'b0;
      #1 reset_check("midop");
      repeat (2) @(posedge clock);
      #2 reset = 1'b1;
      model_reset();
      for (int i = 0; i < RUN_AT; i++) idle();
      step(1'b1, 8'h12, 1'b0, '0, '0, '0, d_rr, d_wr, d_en, d_wm, d_rv, d_rd);
      step(1'b1, 8'h03, 1'b1, 8'h05, rand_data(), 10'h3FF, d_rr, d_wr, d_en, d_wm, d_rv, d_rd);
      for (int i = 0; i < 40; i++) begin
         step($urandom_range(0, 1) == 1, ADDR_W'($urandom_range(0, 7)),
              $urandom_range(0, 1) == 1, ADDR_W'($urandom_range(0, 7)),
              rand_data(), WAYS'($urandom), d_rr, d_wr, d_en, d_wm, d_rv, d_rd);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
